// File: rtl/s2p_frame_reg.sv
// Framed serial-to-parallel converter with a valid/ack output register and overrun flag.
// Optional trailing even-parity bit per frame: define S2P_FRAME_PARITY_EN.
module s2p_frame_reg #(
    parameter int W         = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin,
    input  logic         en,
    input  logic         sync,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);
    localparam int CW = $clog2(W + 1);

`ifdef S2P_FRAME_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_shift;
    logic [W-1:0]    w_shift_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [CW-1:0]   w_cnt_inc;
    logic [W-1:0]    w_base;
    logic [W-1:0]    w_shifted;
    logic            w_accept;
    logic            w_complete;
    logic            w_load;
    logic [W-1:0]    w_load_word;
    logic [W-1:0]    r_y;
    logic            r_valid;
    logic            r_overrun;

    // A sync bit starts from an empty register, so partial frames never leak into the new word.
    assign w_base    = sync ? '0 : r_shift;
    assign w_cnt_inc = sync ? CW'(1) : r_count + CW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : gen_bits
            if (MSB_FIRST) begin : gen_msb
                if (gi == 0) begin : gen_ins
                    assign w_shifted[gi] = sin;
                end else begin : gen_mov
                    assign w_shifted[gi] = w_base[gi-1];
                end
            end else begin : gen_lsb
                if (gi == W - 1) begin : gen_ins
                    assign w_shifted[gi] = sin;
                end else begin : gen_mov
                    assign w_shifted[gi] = w_base[gi+1];
                end
            end
        end
    endgenerate

    assign w_accept   = en && (sync || (r_state == SHIFT));
    assign w_complete = w_accept && (w_cnt_inc == CW'(W));

`ifdef S2P_FRAME_PARITY_EN
    logic r_parity_err;
    logic w_load_perr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_count_next = r_count;
        w_load       = 1'b0;
        w_load_word  = w_shifted;
`ifdef S2P_FRAME_PARITY_EN
        w_load_perr  = 1'b0;
`endif
        if (w_accept) begin
            w_shift_next = w_shifted;
            w_count_next = w_cnt_inc;
            w_state_next = SHIFT;
            if (w_complete) begin
`ifdef S2P_FRAME_PARITY_EN
                w_state_next = PAR;
`else
                w_state_next = IDLE;
                w_count_next = '0;
                w_load       = 1'b1;
`endif
            end
        end
`ifdef S2P_FRAME_PARITY_EN
        else if (en && (r_state == PAR)) begin
            // Even parity: the XOR over data and parity bit must be zero.
            w_state_next = IDLE;
            w_count_next = '0;
            w_load       = 1'b1;
            w_load_word  = r_shift;
            w_load_perr  = ^{r_shift, sin};
        end
`endif
    end

    // Output register: a word arriving while the previous one is unconsumed is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load && (!r_valid || ack)) begin
                r_y     <= w_load_word;
                r_valid <= 1'b1;
            end else if (r_valid && ack) begin
                r_valid <= 1'b0;
            end
            if (r_valid && ack) begin
                r_overrun <= 1'b0;
            end else if (w_load && r_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef S2P_FRAME_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_load && (!r_valid || ack)) begin
            r_parity_err <= w_load_perr;
        end else if (r_valid && ack) begin
            r_parity_err <= 1'b0;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign y       = r_y;
    assign valid   = r_valid;
    assign overrun = r_overrun;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_s2p_frame_reg.sv
// Bench for s2p_frame_reg: three instances (W=8 MSB-first, W=8 LSB-first, W=4 MSB-first)
// share one stimulus stream and are compared each cycle against a bit-list frame model.
module tb_s2p_frame_reg;
`ifdef S2P_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic sin, en, sync, ack;
    logic [7:0] y_a, y_b;
    logic [3:0] y_c;
    logic [2:0] d_valid, d_busy, d_ovr, d_perr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    s2p_frame_reg #(.W(8), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .sin(sin), .en(en), .sync(sync), .ack(ack),
        .y(y_a), .valid(d_valid[0]), .busy(d_busy[0]), .overrun(d_ovr[0]),
        .parity_err(d_perr[0])
    );
    s2p_frame_reg #(.W(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .sin(sin), .en(en), .sync(sync), .ack(ack),
        .y(y_b), .valid(d_valid[1]), .busy(d_busy[1]), .overrun(d_ovr[1]),
        .parity_err(d_perr[1])
    );
    s2p_frame_reg #(.W(4), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .sin(sin), .en(en), .sync(sync), .ack(ack),
        .y(y_c), .valid(d_valid[2]), .busy(d_busy[2]), .overrun(d_ovr[2]),
        .parity_err(d_perr[2])
    );

    function automatic int kw(input int k);
        return (k == 2) ? 4 : 8;
    endfunction
    function automatic bit km(input int k);
        return (k != 1);
    endfunction
    function automatic logic [63:0] dut_y(input int k);
        case (k)
            0:       return {56'd0, y_a};
            1:       return {56'd0, y_b};
            default: return {60'd0, y_c};
        endcase
    endfunction

    // Reference model: the bits of the current frame in arrival order.
    bit          m_in    [3];
    int          m_cnt   [3];
    logic [64:0] m_bits  [3];
    logic [63:0] m_y     [3];
    bit          m_valid [3];
    bit          m_ovr   [3];
    bit          m_perr  [3];

    task automatic model_step(input int k);
        bit done = 0;
        logic [63:0] word = '0;
        bit pe = 0;
        if (en) begin
            if (sync) begin
                m_in[k]  = 1;
                m_cnt[k] = 0;
            end
            if (m_in[k]) begin
                m_bits[k][m_cnt[k]] = sin;
                m_cnt[k]++;
                if (m_cnt[k] == kw(k) + PB) begin
                    done    = 1;
                    m_in[k] = 0;
                    for (int i = 0; i < kw(k); i++) begin
                        if (km(k)) word[kw(k)-1-i] = m_bits[k][i];
                        else       word[i]         = m_bits[k][i];
                    end
                    if (PB == 1)
                        for (int i = 0; i <= kw(k); i++) pe ^= m_bits[k][i];
                end
            end
        end
        if (done && (!m_valid[k] || ack)) begin
            $display("xfer inst=%0d word=%h perr=%0b loaded", k, word, pe);
            if (m_valid[k]) m_ovr[k] = 0;
            m_y[k]     = word;
            m_perr[k]  = pe;
            m_valid[k] = 1;
        end else if (done) begin
            $display("xfer inst=%0d word=%h perr=%0b dropped", k, word, pe);
            m_ovr[k] = 1;
        end else if (m_valid[k] && ack) begin
            m_valid[k] = 0;
            m_perr[k]  = 0;
            m_ovr[k]   = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_in[k] = 0; m_cnt[k] = 0; m_bits[k] = '0; m_y[k] = '0;
                m_valid[k] = 0; m_ovr[k] = 0; m_perr[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("y%0d", k), dut_y(k), m_y[k]);
            chk($sformatf("valid%0d", k), 64'(d_valid[k]), 64'(m_valid[k]));
            chk($sformatf("busy%0d", k), 64'(d_busy[k]), 64'(m_in[k]));
            chk($sformatf("ovr%0d", k), 64'(d_ovr[k]), 64'(m_ovr[k]));
            chk($sformatf("perr%0d", k), 64'(d_perr[k]), 64'(m_perr[k]));
        end
    endtask

    task automatic tick(input logic e, input logic s, input logic sy, input logic a);
        en = e; sin = s; sync = sy; ack = a;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // pat holds the first bit at position n-1; gap idle cycles follow each bit.
    task automatic send_frame(input logic [15:0] pat, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, pat[n-1-i], (i == 0), 1'b0);
            repeat (gap) tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic pulse_reset();
        en = 0; sin = 0; sync = 0; ack = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(d_busy), 64'd0);
        chk("rst_valid", 64'(d_valid), 64'd0);
        chk("rst_y", {y_a, y_b, y_c}, 64'd0);
        check_all();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 0; sin = 0; sync = 0; ack = 0;
        repeat (2) @(negedge clk);
        chk("reset_y", {y_a, y_b, y_c}, 64'd0);
        chk("reset_flags", {d_valid, d_busy, d_ovr, d_perr}, 64'd0);
        check_all();
        rst_n = 1'b1;

        // A5 stream, palindrome in both bit orders
        send_frame(16'h00A5, 8, 0);
        if (PB == 1) tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a5_msb", 64'(y_a), 64'hA5);
        chk("a5_lsb", 64'(y_b), 64'hA5);
        chk("a5_valid", 64'(d_valid[0]), 64'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5_ack", 64'(d_valid[0]), 64'd0);

        send_frame(16'h00C0, 8, 0);
        if (PB == 1) tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("c0_lsb", 64'(y_b), 64'h03);
        chk("c0_msb", 64'(y_a), 64'hC0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Resync mid-frame: earlier bits discarded
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, (i == 0), 1'b0);
            chk("resync_busy", 64'(d_busy[0]), 64'd1);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("resync_busy", 64'(d_busy[0]), 64'd1);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            if (i < 6) chk("resync_busy", 64'(d_busy[0]), 64'd1);
        end
        if (PB == 1) tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("resync_y", 64'(y_a), 64'h80);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Gapped enable with ack held low: second word overruns
        if (PB == 1) begin
            send_frame(16'h001E, 5, 2);
            send_frame(16'h0003, 5, 2);
        end else begin
            send_frame(16'h000F, 4, 2);
            send_frame(16'h0001, 4, 2);
        end
        chk("ovr_keep_y", 64'(y_c), 64'hF);
        chk("ovr_valid", 64'(d_valid[2]), 64'd1);
        chk("ovr_set", 64'(d_ovr[2]), 64'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_ack_valid", 64'(d_valid[2]), 64'd0);
        chk("ovr_ack_clr", 64'(d_ovr[2]), 64'd0);

        // Reset mid-frame, then a clean frame
        send_frame(16'h0002, 2, 0);
        pulse_reset();
        if (PB == 1) send_frame(16'h0012, 5, 0);
        else         send_frame(16'h0009, 4, 0);
        chk("post_rst_y", 64'(y_c), 64'h9);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef S2P_FRAME_PARITY_EN
        send_frame(16'h0A5 << 1, 9, 0);
        chk("par_ok", 64'(d_perr[0]), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame((16'h0A5 << 1) | 16'h1, 9, 0);
        chk("par_bad", 64'(d_perr[0]), 64'd1);
        chk("par_valid", 64'(d_valid[0]), 64'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("par_clr", 64'(d_perr[0]), 64'd0);
`endif

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) pulse_reset();
            tick(($urandom_range(0, 2) != 0), 1'($urandom), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/s2p_frame_reg.md
Name: s2p_frame_reg

Overview:
Parametrised serial-to-parallel converter. It assembles a framed serial bit stream into a W-bit word and holds it in an enable-gated output register. The word is presented to the downstream consumer with a valid/ack handshake and overrun detection. It is the successor of the fixed 16-bit clock-enable register stage in the S2P path: it adds width generalisation, bit-order mode, framing and flow control.

Parameters:
W, 16, word width in bits; legal range 1..64.
MSB_FIRST, 1, 1 = first serial bit lands in y[W-1]; 0 = first bit lands in y[0].

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst_n  input  1  asynchronous active-low reset.
sin  input  1  serial data bit; sampled only when en=1.
en  input  1  bit strobe; one bit accepted per clk edge with en=1.
sync  input  1  frame start; qualified by en; marks sin as bit 0 of a new frame.
ack  input  1  consumer accepts y; meaningful only while valid=1.
y  output  W  assembled parallel word (registered).
valid  output  1  y holds an unconsumed word.
busy  output  1  frame assembly in progress (state != IDLE).
overrun  output  1  sticky: a completed word was dropped.
parity_err  output  1  parity error on last loaded word (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, shift reg=0, bit count=0, y=0, valid=0, overrun=0, parity_err=0, busy=0.
- States: IDLE, SHIFT, and PAR (PAR exists only with the macro).
- IDLE:
  - en=1 & sync=1: capture sin as bit 0, count=1, go to SHIFT.
  - en=1 & sync=0: ignore the bit.
  - en=0: hold.
- SHIFT:
  - en=0: hold state and count.
  - en=1 & sync=0: accept bit, count+1.
  - en=1 & sync=1: discard the partial frame; sin becomes bit 0 of a new frame; count=1.
- Word completion: the edge that accepts the W-th bit is the completion edge.
  - Without the macro: load y and go to IDLE on that edge.
  - With the macro: go to PAR instead.
  - y and valid update on the load edge, so valid is high in the cycle after the last bit is sampled. Latency from last bit to valid is 1 clk.
- W=1: the sync bit itself completes the word on the same edge.
- Bit order:
  - MSB_FIRST=1: shift left and insert at LSB; final word has first bit at y[W-1].
  - MSB_FIRST=0: shift right and insert at MSB; first bit ends at y[0].
- The load value includes the bit arriving on the completion edge (no extra cycle).
- Handshake:
  - valid stays 1 until ack=1 is sampled; valid clears on that edge.
  - y is stable while valid=1.
- Simultaneous load and ack (valid=1): the new word loads, valid stays 1, no overrun.
- Load while valid=1 & ack=0: the new word is dropped, y is unchanged, and overrun is set to 1.
  - overrun is sticky and clears on the next edge with ack=1 (the drop edge itself has ack=0).
- ack while valid=0: ignored.
- busy is combinational from state: 1 in SHIFT/PAR, 0 in IDLE.
- Reset asserted mid-frame or while valid=1: everything returns to reset values immediately; the partial word is lost.

Optional Feature:
- Macro: S2P_FRAME_PARITY_EN.
- Defined: each frame is W data bits followed by one even-parity bit.
  - After the W-th data bit, the block enters PAR and accepts the next en bit as parity.
  - sync=1 with en=1 in PAR: abort and restart as in SHIFT; no load.
  - On the parity edge: load y/valid as normal; parity_err = (XOR of data bits) XOR parity bit.
  - parity_err is updated on every load and cleared on ack together with valid.
  - Latency: valid rises 1 clk after the parity bit is sampled.
- Undefined: no PAR state, the word completes on the W-th bit, and parity_err is tied 0.

Test Plan:
- W=8, MSB_FIRST=1, sync with first bit, en=1 for bits 1,0,1,0,0,1,0,1 -> y=8'hA5, valid=1 one clk after the 8th bit; ack -> valid=0 next clk.
- W=8, MSB_FIRST=0, same stream -> y=8'hA5 bit-reversed = 8'hA5 (palindrome check); repeat with 1,1,0,0,0,0,0,0 -> y=8'h03.
- W=8, 3 bits then sync with bit 1, then 7 further bits all 0 -> y=8'h80 (MSB_FIRST=1); the earlier 3 bits are discarded; busy=1 throughout.
- W=4, en gapped (en=1 every 3rd clk), frame 1,1,1,1, ack held 0, then second frame 0,0,0,1 -> first y=4'hF kept, overrun=1 after second completion; ack -> valid=0, overrun=0.
- W=4, rst_n pulsed low after 2 bits -> y=0, valid=0, busy=0 immediately; next sync frame 1,0,0,1 -> y=4'h9.
- With S2P_FRAME_PARITY_EN, W=8: data 8'hA5 + parity 0 -> parity_err=0; data 8'hA5 + parity 1 -> parity_err=1; valid 1 clk after the parity bit.
